proto245_txsched: RTL and testbench



---
 rtl/proto245_txsched.sv | 187 ++++++++++++++++++
 tb/tb_proto245_txsched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proto245_txsched.sv
`default_nettype none
// ============================================================================
//  Module   : proto245_txsched
//  Function : Round-robin packet scheduler feeding the FT245 bridge TX FIFO.
//             Each grant is written atomically as {channel, length, payload}
//             once the FIFO has room for the whole frame.
//  Revision : 1.0  initial release
// ============================================================================
module proto245_txsched #(
    parameter int DATA_W         = 8,
    parameter int CH_N           = 4,
    parameter int TX_FIFO_SIZE   = 4096,
    parameter int TX_FIFO_LOAD_W = $clog2(TX_FIFO_SIZE) + 1,
    parameter int CH_W           = $clog2(CH_N)
) (
    input  logic                      txfifo_clk,
    input  logic                      txfifo_rstn,
    input  logic                      en,
    input  logic [CH_N-1:0]           ch_req,
    input  logic [CH_N*DATA_W-1:0]    ch_len,
    output logic [CH_N-1:0]           ch_gnt,
    input  logic [CH_N*DATA_W-1:0]    ch_data,
    input  logic [CH_N-1:0]           ch_valid,
    output logic [CH_N-1:0]           ch_ready,
    output logic [DATA_W-1:0]         txfifo_data,
    output logic                      txfifo_wr,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      busy,
    output logic                      pkt_done
);

    // Space arithmetic is wide enough for both the load counter and len+3
    localparam int CALC_W = (TX_FIFO_LOAD_W > DATA_W + 2) ? TX_FIFO_LOAD_W : DATA_W + 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_HDR_CH  = 3'd2;
    localparam logic [2:0] S_HDR_LEN = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_GAP0    = 3'd5;
    localparam logic [2:0] S_GAP1    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   g_q, g_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_N-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;

    logic              arb_found;
    logic [CH_W-1:0]   arb_idx;
    int                arb_best;
    int                arb_dist;

    logic [CALC_W-1:0] free_w;
    logic [CALC_W-1:0] need_w;
    logic              space_ok;
    logic              acc;
    logic [DATA_W-1:0] cur_data;

    assign free_w   = CALC_W'(TX_FIFO_SIZE) - CALC_W'(txfifo_load);
    assign need_w   = CALC_W'(len_q) + CALC_W'(3);
    assign space_ok = (free_w >= need_w) && !txfifo_full;
    assign acc      = (state_q == S_DATA) && ch_valid[g_q];
    assign cur_data = ch_data[g_q*DATA_W +: DATA_W];

    assign busy        = (state_q != S_IDLE);
    assign txfifo_wr   = wr_q;
    assign txfifo_data = data_q;
    assign ch_gnt      = gnt_q;
    assign pkt_done    = done_q;

    // Round-robin pick: smallest upward distance from last+1 among requesters
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_best  = CH_N;
        arb_dist  = 0;
        for (int j = 0; j < CH_N; j++) begin
            arb_dist = (j + CH_N - 1 - int'(last_q)) % CH_N;
            if (ch_req[j] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                arb_idx   = CH_W'(j);
                arb_found = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge txfifo_clk or negedge txfifo_rstn) begin
        if (!txfifo_rstn) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            last_q  <= CH_W'(CH_N - 1);
            len_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: a withdrawn request in CHECK returns to IDLE without a grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (en && arb_found) state_d = S_CHECK;
            S_CHECK: begin
                if (!ch_req[g_q])  state_d = S_IDLE;
                else if (space_ok) state_d = S_HDR_CH;
            end
            S_HDR_CH:  state_d = S_HDR_LEN;
            S_HDR_LEN: state_d = S_DATA;
            S_DATA:    if (acc && (cnt_q == '0)) state_d = S_GAP0;
            S_GAP0:    state_d = S_GAP1;
            S_GAP1:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; writes follow acceptance by one cycle
    always_comb begin
        g_d      = g_q;
        last_d   = last_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        data_d   = '0;
        gnt_d    = '0;
        done_d   = 1'b0;
        ch_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (en && arb_found) begin
                    g_d   = arb_idx;
                    len_d = ch_len[arb_idx*DATA_W +: DATA_W];
                end
            end
            S_CHECK: begin
                if (ch_req[g_q] && space_ok) begin
                    gnt_d[g_q] = 1'b1;
                    last_d     = g_q;
                end
            end
            S_HDR_CH: begin
                wr_d   = 1'b1;
                data_d = DATA_W'(g_q);
            end
            S_HDR_LEN: begin
                wr_d   = 1'b1;
                data_d = len_q;
                cnt_d  = len_q;
            end
            S_DATA: begin
                ch_ready[g_q] = 1'b1;
                if (acc) begin
                    wr_d   = 1'b1;
                    data_d = cur_data;
                    if (cnt_q == '0) done_d = 1'b1;
                    else             cnt_d  = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The CHECK reservation guarantees the FIFO never fills during a frame
    a_no_full_in_frame: assert property (@(posedge txfifo_clk) disable iff (!txfifo_rstn)
        !(txfifo_wr && txfifo_full));

endmodule
`default_nettype wire

// File: tb/tb_proto245_txsched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_proto245_txsched
//  Function : Self-checking bench for proto245_txsched with a frame-level
//             reference model (round-robin order, frame contents, pkt_done).
//  Revision : 1.0  initial release
// ============================================================================
module tb_proto245_txsched;
    localparam int DATA_W = 8;
    localparam int CH_N   = 4;
    localparam int SIZE   = 4096;
    localparam int LOAD_W = 13;
    localparam int PAY_N  = 1024;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   en;
    logic [CH_N-1:0]        ch_req;
    logic [CH_N*DATA_W-1:0] ch_len;
    logic [CH_N-1:0]        ch_gnt;
    logic [CH_N*DATA_W-1:0] ch_data;
    logic [CH_N-1:0]        ch_valid;
    logic [CH_N-1:0]        ch_ready;
    logic [DATA_W-1:0]      txfifo_data;
    logic                   txfifo_wr;
    logic [LOAD_W-1:0]      txfifo_load;
    logic                   txfifo_full;
    logic                   busy;
    logic                   pkt_done;

    always #5 clk = ~clk;

    proto245_txsched #(.DATA_W(DATA_W), .CH_N(CH_N), .TX_FIFO_SIZE(SIZE)) dut (
        .txfifo_clk(clk), .txfifo_rstn(rstn), .en(en),
        .ch_req(ch_req), .ch_len(ch_len), .ch_gnt(ch_gnt),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr),
        .txfifo_load(txfifo_load), .txfifo_full(txfifo_full),
        .busy(busy), .pkt_done(pkt_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]      pay  [CH_N][PAY_N];
    logic [7:0]      lens [CH_N][8];
    int              pidx [CH_N];
    int              eidx [CH_N];
    int              rem_drv [CH_N];
    int              kd [CH_N];
    int              km [CH_N];
    int              vprob [CH_N];
    logic [CH_N-1:0] acc_prev;
    int              mlast;

    logic [7:0]      wq[$];
    logic [7:0]      eq[$];
    int              dq[$];
    int              edq[$];
    logic [CH_N-1:0] gq[$];
    logic [CH_N-1:0] egq[$];
    int first_wr_cyc, last_wr_cyc, gnt_cyc, req_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester behaviour: hold request/length until granted, stream payload
    task automatic apply_inputs();
        for (int c = 0; c < CH_N; c++) begin
            ch_req[c]            = (rem_drv[c] > 0);
            ch_len[c*8 +: 8]     = lens[c][kd[c] % 8];
            ch_data[c*8 +: 8]    = pay[c][pidx[c] % PAY_N];
            ch_valid[c]          = ($urandom_range(99) < vprob[c]);
        end
        acc_prev = ch_valid & ch_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < CH_N; c++) if (acc_prev[c]) pidx[c]++;
        if (txfifo_wr) begin
            if (wq.size() == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wq.push_back(txfifo_data);
        end
        if (pkt_done) dq.push_back(wq.size());
        if (ch_gnt != '0) begin
            gq.push_back(ch_gnt);
            gnt_cyc = cyc;
            for (int c = 0; c < CH_N; c++) begin
                if (ch_gnt[c]) begin
                    if (rem_drv[c] > 0) rem_drv[c]--;
                    kd[c]++;
                end
            end
        end
        apply_inputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_len(input int c, input int v);
        for (int k = 0; k < 8; k++) lens[c][k] = 8'(v);
    endtask

    // Reference model: one frame = channel id, length code, len+1 payload words
    task automatic model_pkt(input int c);
        logic [CH_N-1:0] m;
        int len;
        len = int'(lens[c][km[c] % 8]);
        km[c]++;
        m = '0;
        m[c] = 1'b1;
        egq.push_back(m);
        eq.push_back(8'(c));
        eq.push_back(8'(len));
        for (int k = 0; k <= len; k++) eq.push_back(pay[c][(eidx[c] + k) % PAY_N]);
        eidx[c] += len + 1;
        edq.push_back(eq.size());
        mlast = c;
    endtask

    // Round-robin over channels with outstanding packet counts
    task automatic model_rr(input int rem [CH_N]);
        int r [CH_N];
        bit found;
        for (int c = 0; c < CH_N; c++) r[c] = rem[c];
        do begin
            int pick;
            found = 1'b0;
            pick  = 0;
            for (int i = 1; i <= CH_N; i++) begin
                int c;
                c = (mlast + i) % CH_N;
                if (!found && r[c] > 0) begin
                    found = 1'b1;
                    pick  = c;
                end
            end
            if (found) begin
                r[pick]--;
                model_pkt(pick);
            end
        end while (found);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (dq.size() < target && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", (dq.size() >= target) ? 32'd1 : 32'd0, 32'd1);
        ticks(3);
    endtask

    task automatic compare(input string tag);
        int n;
        check($sformatf("%s_nwords", tag), wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), wq[i], eq[i]);
        check($sformatf("%s_ndone", tag), dq.size(), edq.size());
        n = (dq.size() < edq.size()) ? dq.size() : edq.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_done_pos%0d", tag, i), dq[i], edq[i]);
        check($sformatf("%s_ngnt", tag), gq.size(), egq.size());
        n = (gq.size() < egq.size()) ? gq.size() : egq.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_gnt%0d", tag, i), gq[i], egq[i]);
        wq.delete(); eq.delete(); dq.delete(); edq.delete(); gq.delete(); egq.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr"},    txfifo_wr,   0);
        check({tag, "_data"},  txfifo_data, 0);
        check({tag, "_gnt"},   ch_gnt,      0);
        check({tag, "_ready"}, ch_ready,    0);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_done"},  pkt_done,    0);
    endtask

    initial begin
        int r [CH_N];
        int total;
        int n;

        for (int c = 0; c < CH_N; c++) begin
            for (int k = 0; k < PAY_N; k++) pay[c][k] = 8'($urandom);
            pidx[c] = 0; eidx[c] = 0; rem_drv[c] = 0; kd[c] = 0; km[c] = 0;
            vprob[c] = 100;
            set_len(c, 0);
        end
        mlast       = CH_N - 1;
        en          = 1'b1;
        txfifo_load = '0;
        txfifo_full = 1'b0;
        ch_req = '0; ch_len = '0; ch_data = '0; ch_valid = '0;
        acc_prev = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        apply_inputs();

        // Round-robin after reset: channel 0 first, each frame 3 words
        for (int c = 0; c < CH_N; c++) begin set_len(c, 0); r[c] = 1; end
        r[0] = 2;
        for (int c = 0; c < CH_N; c++) rem_drv[c] = r[c];
        apply_inputs();
        model_rr(r);
        wait_done(5, 300);
        compare("rr");

        // Single packet: ch1 len=3, latency and back-to-back frame words
        set_len(1, 3);
        rem_drv[1] = 1;
        apply_inputs();
        req_cyc = cyc;
        wait_done(1, 50);
        check("single_gnt_latency", gnt_cyc - req_cyc, 2);
        check("single_first_wr_latency", first_wr_cyc - req_cyc, 3);
        check("single_frame_span", last_wr_cyc - first_wr_cyc, 5);
        model_pkt(1);
        compare("single");

        // Space wait: 3 free words, withdrawn request, then exact fit
        txfifo_load = LOAD_W'(SIZE - 3);
        set_len(1, 1);
        rem_drv[1] = 1;
        apply_inputs();
        ticks(6);
        check("drop_busy_in_check", busy, 1);
        check("drop_no_writes", wq.size(), 0);
        rem_drv[1] = 0;
        apply_inputs();
        ticks(2);
        check("drop_back_to_idle", busy, 0);
        check("drop_no_grant", gq.size(), 0);
        set_len(0, 1);
        rem_drv[0] = 1;
        apply_inputs();
        ticks(10);
        check("space_hold_busy", busy, 1);
        check("space_hold_no_writes", wq.size(), 0);
        txfifo_load = LOAD_W'(SIZE - 4);
        txfifo_full = 1'b1;
        ticks(5);
        check("full_hold_no_grant", gq.size(), 0);
        txfifo_full = 1'b0;
        wait_done(1, 50);
        model_pkt(0);
        compare("space");
        txfifo_load = '0;

        // Maximum length with an irregular requester
        set_len(2, 255);
        vprob[2] = 70;
        rem_drv[2] = 1;
        apply_inputs();
        wait_done(1, 1500);
        check("max_nwords", wq.size(), 258);
        check("max_len_word", (wq.size() > 1) ? wq[1] : 8'h00, 8'hFF);
        model_pkt(2);
        compare("max");

        // Enable dropped mid-packet; pending ch0 waits until enable returns
        set_len(3, 5);
        vprob[3] = 50;
        rem_drv[3] = 1;
        apply_inputs();
        n = 0;
        while (gq.size() == 0 && n < 20) begin tick(); n++; end
        check("en_grant_seen", gq.size(), 1);
        en = 1'b0;
        set_len(0, 2);
        rem_drv[0] = 1;
        apply_inputs();
        wait_done(1, 200);
        ticks(20);
        check("en_low_no_new_grant", gq.size(), 1);
        check("en_low_idle", busy, 0);
        en = 1'b1;
        apply_inputs();
        wait_done(2, 200);
        model_pkt(3);
        model_pkt(0);
        compare("en");

        // Randomised rounds: counts, lengths and valid rates per channel
        for (int round = 0; round < 3; round++) begin
            total = 0;
            for (int c = 0; c < CH_N; c++) begin
                r[c] = int'($urandom_range(3));
                total += r[c];
                for (int k = 0; k < 8; k++) lens[c][k] = 8'($urandom_range(15));
                vprob[c] = int'($urandom_range(100, 30));
                rem_drv[c] = r[c];
            end
            apply_inputs();
            model_rr(r);
            wait_done(total, 3000);
            compare($sformatf("rand%0d", round));
        end

        // Asynchronous reset in the middle of a payload
        for (int c = 0; c < CH_N; c++) vprob[c] = 100;
        set_len(2, 20);
        rem_drv[2] = 1;
        apply_inputs();
        n = 0;
        while (ch_ready == '0 && n < 20) begin tick(); n++; end
        check("rst_reached_data", ch_ready, 4'b0100);
        ticks(3);
        #2 rstn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        for (int c = 0; c < CH_N; c++) rem_drv[c] = 0;
        apply_inputs();
        @(negedge clk);
        rstn = 1'b1;
        wq.delete(); eq.delete(); dq.delete(); edq.delete(); gq.delete(); egq.delete();
        mlast = CH_N - 1;
        for (int c = 0; c < CH_N; c++) begin eidx[c] = pidx[c]; km[c] = kd[c]; end
        set_len(0, 2);
        set_len(3, 2);
        rem_drv[0] = 1;
        rem_drv[3] = 1;
        apply_inputs();
        for (int c = 0; c < CH_N; c++) r[c] = rem_drv[c];
        model_rr(r);
        wait_done(2, 200);
        check("post_rst_first_gnt", (gq.size() > 0) ? gq[0] : 4'b0000, 4'b0001);
        compare("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
